seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit seven-segment scan driver for the watch display, sitting directly downstream of the clock divider. It consumes the divider's slow toggle output (`newclk`) as a scan-rate reference in the `clk` domain, using it as a data signal and never as a clock. Each toggle advances one digit. The block snapshots the BCD time value once per frame, decodes it and drives active-low anode and segment lines. A short all-off blanking gap at each digit change suppresses ghosting.

## Interface
- `BLANK_CYCLES`, default 4: `clk` cycles all anodes stay off after each digit advance. Legal range is 1..255 and it must be shorter than one `scan_clk` half-period.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `scan_clk`  in  1  divider toggle output, already in the `clk` domain; each level change is one scan tick.
- `digits`  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_mask`  in  4  decimal point enable per digit, 1 = lit.
- `lz_en`  in  1  leading-zero suppression enable.
- `an`  out  4  anode select, active-low, one-hot-low or all ones.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `overrun`  out  1  sticky flag: a tick was dropped during BLANK.

## Operation
- Tick detection: `scan_q` is a register of `scan_clk`, and `tick = scan_clk ^ scan_q`. While `rst_n` = 0, `scan_q` loads `scan_clk`, so no spurious tick occurs at reset release.
- States:
  - OFF is the post-reset state, with all outputs dark.
  - BLANK holds anodes off while the blank counter runs.
  - SHOW drives digit `idx`.
- Transitions:
  - OFF + tick → BLANK, with `idx` = 0 and the snapshot taken.
  - BLANK → SHOW on the edge where `cnt` == `BLANK_CYCLES`-1. BLANK therefore lasts exactly `BLANK_CYCLES` cycles.
  - SHOW + tick → BLANK, `cnt` = 0, `idx` = `idx`+1 mod 4. When `idx` wraps 3→0, the snapshot is retaken.
  - BLANK + tick: the tick is dropped, the state is unaffected, and `overrun` is set to 1. `overrun` clears only on reset.
- Snapshot: `digits`, `dp_mask` and `lz_en` are copied into internal registers as a frame starts. The display never mixes two time values within one frame.
- Decode from the snapshot nibble:
  - 0–9 map to standard glyphs.
  - 10–15 show a dash: `seg` = 7'b0111111, segment g only.
- Leading-zero suppression, with `lz_en` = 1 in the snapshot:
  - Digit 3 is blank if its nibble is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digits 1 and 0 are never suppressed.
  - A blank digit drives `seg` = 7'h7F. Its `dp` still follows `dp_mask`.
- In SHOW: `an` = ~(4'b0001 << `idx`), `seg` is the decoded glyph, and `dp` = ~`dp_mask`[`idx`].

## Timing
- Reset values:
  - `an` = 4'hF, `seg` = 7'h7F, `dp` = 1, `overrun` = 0.
  - State OFF, `idx` = 0, `cnt` = 0.
  - Snapshot registers = 0.
- Reset mid-frame takes effect on the next edge with `rst_n` low: the outputs go dark at once and the block waits for a fresh tick.
- `an`, `seg` and `dp` are registered and update on the same edge as the state register. No combinational path runs from inputs to outputs.
- Tick latency:
  - A `scan_clk` change that is sampled high-vs-`scan_q` at edge t makes `an` = 4'hF from edge t.
  - The new digit drives from edge t+`BLANK_CYCLES`.
- Segment and anode changes never overlap. `an` is all ones for at least `BLANK_CYCLES` cycles around every digit change.
- The snapshot is taken at the same edge t that starts BLANK for digit 0. Input changes after edge t are not shown until the next frame.
- A tick in the same cycle as the BLANK→SHOW transition is a BLANK tick: it is dropped and flagged.

## Structure
- Package `watch_pkg`:
  - Glyph constants `SEG_0`..`SEG_9`, `SEG_DASH` and `SEG_OFF`.
  - State enum {OFF, BLANK, SHOW}.
  - `NUM_DIGITS` = 4.
- Sub-module `bcd_to_seg`: combinational, 4-bit nibble in, 7-bit active-low glyph out, reused by other display blocks.
- `cnt` width is 8 bits, matching the `BLANK_CYCLES` maximum of 255.

## Test plan
- Reset release with `scan_clk` = 1 and no toggles → `an` = F, `seg` = 7F, `dp` = 1, `overrun` = 0 indefinitely.
- `digits` = 16'h1234, `dp_mask` = 4'b0100, `lz_en` = 0, toggling every 20 cycles → per frame `an` cycles E,D,B,7.
  - `seg` values are 0x19, 0x30, 0x24, 0x79.
  - `dp` is low only while `an` = B.
  - `an` = F for exactly 4 cycles before each digit.
- `digits` = 16'h0005, `lz_en` = 1 → digits 3 and 2 have `seg` = 7F while digit 1 shows 0x40 and digit 0 shows 0x12. Repeating with `digits` = 16'h0A05 → digit 3 is blank and digit 2 shows 0x3F.
- `digits` changed from 16'h1111 to 16'h2222 while `idx` = 1 → digits 2 and 3 of that frame still show 1. The next frame shows 2 on all digits.
- `BLANK_CYCLES` = 8 with a toggle every 5 cycles → `overrun` goes high on the first dropped tick and stays high. The digits keep advancing only on ticks that arrive in SHOW.
- `rst_n` pulsed low for 1 cycle while in SHOW on `idx` = 2 → outputs are dark from that edge. The next tick restarts at `idx` = 0 with a fresh snapshot.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared display constants for the watch: active-low seven-segment glyphs
// ({g,f,e,d,c,b,a}), scan state encoding and digit count.
package watch_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {OFF, BLANK, SHOW} scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low seven-segment glyph; non-decimal codes show a dash.
module bcd_to_seg
  import watch_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (nibble)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver. Each scan_clk level change
// advances one digit, preceded by an all-anodes-off blanking gap.
module seg_scan
  import watch_pkg::*;
#(
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        overrun
);

  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic        scan_q;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] snap_dig_q, snap_dig_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic        snap_lz_q, snap_lz_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        overrun_q, overrun_d;

  logic        tick;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_glyph;
  logic        lz_blank;

  assign tick    = scan_clk ^ scan_q;
  assign cur_nib = 4'(snap_dig_q >> {idx_q, 2'b00});

  // A digit is a suppressed leading zero when it and every digit above it is 0.
  assign lz_blank = snap_lz_q &&
                    ((idx_q == 2'd3 && snap_dig_q[15:12] == 4'd0) ||
                     (idx_q == 2'd2 && snap_dig_q[15:8]  == 8'd0));

  bcd_to_seg u_dec (.nibble(cur_nib), .glyph(cur_glyph));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    overrun_d  = overrun_q;
    case (state_q)
      OFF: begin
        if (tick) begin
          state_d    = BLANK;
          idx_d      = 2'd0;
          cnt_d      = 8'd0;
          snap_dig_d = digits;
          snap_dp_d  = dp_mask;
          snap_lz_d  = lz_en;
        end
      end
      BLANK: begin
        if (tick) overrun_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = SHOW;
          an_d    = ~(4'b0001 << idx_q);
          seg_d   = lz_blank ? SEG_OFF : cur_glyph;
          dp_d    = ~snap_dp_q[idx_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHOW: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = 8'd0;
          idx_d   = idx_q + 2'd1;
          an_d    = 4'hF;
          seg_d   = SEG_OFF;
          dp_d    = 1'b1;
          if (idx_q == IDX_LAST) begin
            snap_dig_d = digits;
            snap_dp_d  = dp_mask;
            snap_lz_d  = lz_en;
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    scan_q <= scan_clk;
    if (!rst_n) begin
      state_q    <= OFF;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      snap_dig_q <= 16'd0;
      snap_dp_q  <= 4'd0;
      snap_lz_q  <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      overrun_q  <= overrun_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed frames with literal expectations, then random
// scan/data/reset traffic against a cycle-age reference model.
module tb_seg_scan;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  seg_scan #(.BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .digits(digits),
    .dp_mask(dp_mask), .lz_en(lz_en), .an(an), .seg(seg), .dp(dp),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int glyph(int n);
    case (n)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10;
      default: return 'h3F;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: m_age counts edges since the last accepted tick (-1 = dark
  // after reset). A tick is accepted only when the display is already lit.
  int          m_age = -1;
  int          m_idx = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dpm = 4'h0;
  logic        m_lz = 1'b0;
  logic        m_ov = 1'b0;
  logic        m_prev = 1'b1;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin : model
    automatic int   a  = m_age;
    automatic int   i  = m_idx;
    automatic logic tk = scan_clk ^ m_prev;
    mvalid <= 1'b1;
    m_prev <= scan_clk;
    if (!rst_n) begin
      m_age <= -1; m_idx <= 0; m_dig <= 16'h0; m_dpm <= 4'h0;
      m_lz  <= 1'b0; m_ov <= 1'b0;
    end else begin
      if (tk && (a < 0 || a >= BC)) begin
        i = (a < 0) ? 0 : (i + 1) % 4;
        if (i == 0) begin
          m_dig <= digits; m_dpm <= dp_mask; m_lz <= lz_en;
        end
        a = 0;
      end else begin
        if (tk) m_ov <= 1'b1;
        if (a >= 0 && a < 1000) a++;
      end
      m_age <= a;
      m_idx <= i;
    end
  end

  always @(negedge clk) begin : compare
    automatic int e_an = 'hF, e_seg = 'h7F, e_dp = 1, nib;
    automatic bit blank;
    if (mvalid) begin
      if (m_age >= BC) begin
        nib   = (int'(m_dig) >> (4 * m_idx)) & 15;
        blank = m_lz && m_idx >= 2 && (int'(m_dig) >> (4 * m_idx)) == 0;
        e_an  = 'hF ^ (1 << m_idx);
        e_seg = blank ? 'h7F : glyph(nib);
        e_dp  = m_dpm[m_idx] ? 0 : 1;
      end
      chk("an", int'(an), e_an);
      chk("seg", int'(seg), e_seg);
      chk("dp", int'(dp), e_dp);
      chk("overrun", int'(overrun), int'(m_ov));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One accepted tick: dark for BC cycles, then the given digit, 20-cycle slot.
  task automatic step(input string nm, input int e_an, input int e_seg, input int e_dp);
    scan_clk = ~scan_clk;
    cyc(BC);
    chk({nm, "_gap_an"}, int'(an), 'hF);
    cyc(1);
    chk({nm, "_an"}, int'(an), e_an);
    chk({nm, "_seg"}, int'(seg), e_seg);
    chk({nm, "_dp"}, int'(dp), e_dp);
    cyc(15);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(30);
    chk("idle_an", int'(an), 'hF);
    chk("idle_seg", int'(seg), 'h7F);
    chk("idle_dp", int'(dp), 1);
    chk("idle_ov", int'(overrun), 0);

    digits = 16'h1234; dp_mask = 4'b0100; lz_en = 1'b0;
    step("f1d0", 'hE, 'h19, 1);
    step("f1d1", 'hD, 'h30, 1);
    step("f1d2", 'hB, 'h24, 0);
    step("f1d3", 'h7, 'h79, 1);

    digits = 16'h0005; dp_mask = 4'h0; lz_en = 1'b1;
    step("lz0", 'hE, 'h12, 1);
    step("lz1", 'hD, 'h40, 1);
    step("lz2", 'hB, 'h7F, 1);
    step("lz3", 'h7, 'h7F, 1);
    digits = 16'h0A05;
    step("lza0", 'hE, 'h12, 1);
    step("lza1", 'hD, 'h40, 1);
    step("lza2", 'hB, 'h3F, 1);
    step("lza3", 'h7, 'h7F, 1);

    digits = 16'h1111; lz_en = 1'b0;
    step("sn0", 'hE, 'h79, 1);
    step("sn1", 'hD, 'h79, 1);
    digits = 16'h2222;
    step("sn2", 'hB, 'h79, 1);
    step("sn3", 'h7, 'h79, 1);
    step("sn4", 'hE, 'h24, 1);
    step("sn5", 'hD, 'h24, 1);
    step("sn6", 'hB, 'h24, 1);

    rst_n = 1'b0;
    cyc(1);
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    rst_n = 1'b1;
    digits = 16'h9999;
    cyc(10);
    chk("rst_wait_an", int'(an), 'hF);
    step("rs0", 'hE, 'h10, 1);

    chk("ov_before", int'(overrun), 0);
    scan_clk = ~scan_clk;
    cyc(2);
    scan_clk = ~scan_clk;
    cyc(1);
    chk("ov_set", int'(overrun), 1);
    cyc(30);
    chk("ov_sticky", int'(overrun), 1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) scan_clk = ~scan_clk;
      if ($urandom_range(0, 60) == 0) begin
        for (int k = 0; k < 4; k++)
          digits[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_mask = 4'($urandom_range(0, 15));
        lz_en   = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 500) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
